// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared widths, FSM states and constants for the Simon 64/128 controller
package simon_pkg;

   localparam int WORD_W  = 32;
   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // z3 sequence written as the paper string: round i uses Z3[61-i]
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

   // ~k ^ 3 folded into k ^ C
   localparam logic [WORD_W-1:0] C = 32'hFFFFFFFC;

   function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] v, input int unsigned n);
      return (v >> n) | (v << (WORD_W - n));
   endfunction

endpackage

// File: rtl/round_llm.sv
// rtl/round_llm.sv - one combinational Simon 64 Feistel round
module round_llm
   import simon_pkg::*;
(
   input  logic [BLOCK_W-1:0] x,
   input  logic [WORD_W-1:0]  rk,
   output logic [BLOCK_W-1:0] y
);

   logic [WORD_W-1:0] x_hi;
   logic [WORD_W-1:0] x_lo;
   logic [WORD_W-1:0] f;

   assign x_hi = x[BLOCK_W-1:WORD_W];
   assign x_lo = x[WORD_W-1:0];

   // rotate-right by 31/24/30 are the paper's left rotates by 1/8/2
   assign f = (ror32(x_hi, 31) & ror32(x_hi, 24)) ^ ror32(x_hi, 30);
   assign y = {x_lo ^ f ^ rk, x_hi};

endmodule

// File: rtl/simon_iter_ctrl.sv
// rtl/simon_iter_ctrl.sv - iterative Simon 64/128 encryptor, one round per cycle
// with on-the-fly key expansion and valid/ready block handshakes.
module simon_iter_ctrl
   import simon_pkg::*;
#(
   parameter int NUM_ROUNDS = 44
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_block,
   input  logic [KEY_W-1:0]   in_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_block,
   output logic               busy
);

   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   state_t             state;
   logic [5:0]         rnd;
   logic [BLOCK_W-1:0] x;
   logic [WORD_W-1:0]  k [4];
   logic [BLOCK_W-1:0] x_next;
   logic [WORD_W-1:0]  t;
   logic [WORD_W-1:0]  knew;
   logic               z_bit;

   round_llm u_round (
      .x  (x),
      .rk (k[0]),
      .y  (x_next)
   );

   // rnd never exceeds 43, so i mod 62 is simply rnd
   assign z_bit = Z3[6'd61 - rnd];
   assign t     = ror32(k[3], 3) ^ k[1];
   assign knew  = k[0] ^ C ^ t ^ ror32(t, 1) ^ {{(WORD_W-1){1'b0}}, z_bit};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rnd       <= 6'd0;
         x         <= '0;
         for (int i = 0; i < 4; i++) k[i] <= '0;
         out_block <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x        <= in_block;
                  k[0]     <= in_key[31:0];
                  k[1]     <= in_key[63:32];
                  k[2]     <= in_key[95:64];
                  k[3]     <= in_key[127:96];
                  rnd      <= 6'd0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               x    <= x_next;
               k[0] <= k[1];
               k[1] <= k[2];
               k[2] <= k[3];
               k[3] <= knew;
               rnd  <= rnd + 6'd1;
               if (rnd == LAST_ROUND) begin
                  state     <= DONE;
                  out_block <= x_next;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// tb/tb_simon_iter_ctrl.sv - directed-vector bench for simon_iter_ctrl
module tb_simon_iter_ctrl;

   localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [63:0]  PT1  = 64'h656b696c_20646e75;
   localparam logic [63:0]  CT1  = 64'h44c8fc20_b9dfa07a;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0]  in_block = '0;
   logic [127:0] in_key = '0;
   logic         in_ready, out_valid, busy;
   logic [63:0]  out_block;

   logic         in1_valid = 1'b0, out1_ready = 1'b1;
   logic [63:0]  in1_block = '0;
   logic [127:0] in1_key = '0;
   logic         in1_ready, out1_valid, busy1;
   logic [63:0]  out1_block;

   int n_total = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   simon_iter_ctrl #(.NUM_ROUNDS(44)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_block(in_block), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_block(out_block), .busy(busy)
   );

   simon_iter_ctrl #(.NUM_ROUNDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_ready(in1_ready),
      .in_block(in1_block), .in_key(in1_key), .out_valid(out1_valid),
      .out_ready(out1_ready), .out_block(out1_block), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // offer a block at a negedge; returns at the negedge after the accept edge
   task automatic offer(input logic [63:0] blk, input logic [127:0] key);
      in_block = blk;
      in_key   = key;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int  cnt;
      int  t0, t1, nv;
      bit  seen;
      logic [63:0] b0, b1;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_block", out_block, 64'd0);

      // standard vector, latency, then backpressure
      offer(PT1, KEY1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      wait_valid(cnt);
      chk("latency", 64'(cnt), 64'd44);
      chk("ct_std", out_block, CT1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_block", out_block, CT1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_valid_low", 64'(out_valid), 64'd0);
      chk("hs_in_ready", 64'(in_ready), 64'd1);
      chk("hold_block_idle", out_block, CT1);

      // in_valid during RUN must be ignored
      offer(PT1, KEY1);
      repeat (19) @(negedge clk);
      in_block = 64'hdeadbeef_cafef00d;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ign_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      wait_valid(cnt);
      chk("ign_ct", out_block, CT1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      chk("ign_no_second", 64'(seen), 64'd0);

      // reset at round 30
      offer(PT1, KEY1);
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_block", out_block, 64'd0);
      offer(PT1, KEY1);
      wait_valid(cnt);
      chk("post_rst_ct", out_block, CT1);
      out_ready = 1'b1;
      @(negedge clk);

      // back-to-back with in_valid and out_ready held high
      in_block = PT1;
      in_key   = KEY1;
      in_valid = 1'b1;
      nv = 0; t0 = 0; t1 = 0; b0 = '0; b1 = '0;
      for (int c = 0; c < 200 && nv < 2; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (nv == 0) begin t0 = c; b0 = out_block; end
            else begin t1 = c; b1 = out_block; end
            nv++;
         end
      end
      in_valid = 1'b0;
      chk("b2b_count", 64'(nv), 64'd2);
      chk("b2b_ct0", b0, CT1);
      chk("b2b_ct1", b1, CT1);
      chk("b2b_spacing", 64'(t1 - t0), 64'd46);

      // NUM_ROUNDS = 1 instance
      in1_block = 64'h0123456789ABCDEF;
      in1_key   = {96'd0, 32'hFEDCBA98};
      in1_valid = 1'b1;
      out1_ready = 1'b0;
      @(negedge clk);
      in1_valid = 1'b0;
      cnt = 0;
      while (!out1_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("r1_latency", 64'(cnt), 64'd1);
      chk("r1_ct", out1_block, 64'h71be60eb01234567);
      out1_ready = 1'b1;
      @(negedge clk);
      chk("r1_in_ready", 64'(in1_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
